quad_dir_decoder: RTL and testbench
===================================

# quad_dir_decoder

Quadrature rotary-encoder front end that produces the direction (`UD`) and step-qualifier signals consumed by the up/down counter path. It synchronizes and debounces the two encoder phases, tracks the Gray-code phase with a state machine, and emits one step pulse per legal transition. It also maintains a local 4-bit position count for LED display and flags illegal transitions.

## Interface
- `DEB_CYCLES`, default 4: number of consecutive clock edges a synchronized input must differ from its accepted value before the change is accepted. Legal range ≥ 1.
- `clk`  in  1  system clock; all logic on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `enc_a`  in  1  encoder phase A; asynchronous, may bounce
- `enc_b`  in  1  encoder phase B; asynchronous, may bounce
- `UD`  out  1  direction of the last accepted step: 1 = up (CW), 0 = down (CCW); registered
- `step`  out  1  single-cycle pulse, one per accepted legal transition
- `err`  out  1  sticky; set by an illegal (two-bit) phase change
- `LED`  out  4  position count, modulo 16

## Operation
- **Synchronizer:** each of `enc_a`/`enc_b` passes through a 2-flop synchronizer (`a_s`, `b_s`).
- **Debounce**, independent per phase:
  - Each phase keeps an accepted value (`a_st`/`b_st`) and a counter.
  - When the synchronized value differs from the accepted value, the counter increments.
  - When it equals the accepted value, the counter clears.
  - On the edge where the counter would reach `DEB_CYCLES`, the accepted value takes the synchronized value and the counter clears.
- **FSM states:** INIT, S00, S01, S11, S10, where the state name is {A,B}.
  - **INIT:** a settle counter runs for `DEB_CYCLES`+3 edges. At expiry, the FSM moves to the state equal to {`a_st`,`b_st`} with no step and no err.
  - **Up (CW) sequence:** S00→S01→S11→S10→S00. Each move asserts `step`, sets `UD`=1 and increments `LED`.
  - **Down (CCW) sequence:** the reverse order. Each move asserts `step`, sets `UD`=0 and decrements `LED`.
  - **Diagonal change** (both accepted bits change on the same edge, e.g. S00→S11): set `err`, jump to the new state, no `step`, `UD` and `LED` unchanged.
  - **No change:** hold state; `step`=0.
- **Position wrap-around:** 15 +1 → 0; 0 −1 → 15. Arithmetic is unsigned 4-bit with no saturation.
- `err` clears only on `reset`.
- `UD` holds its last value between steps.
- **Reset values**, applied on any edge with `reset`=1, including mid-operation:
  - `UD`=1, `step`=0, `err`=0, `LED`=0
  - Synchronizers, accepted values and counters cleared to 0
  - FSM returns to INIT; all in-flight debounce state is discarded.

## Timing
- Raw input change stable before edge 0:
  - `a_s`/`b_s` reflect it after edge 1.
  - The accepted value updates at edge `DEB_CYCLES`+1.
  - `step`, `UD` and `LED` update at edge `DEB_CYCLES`+2.
  - With the default of 4: `step` is high for exactly the one cycle after edge 6.
- Any pulse or bounce shorter than `DEB_CYCLES` cycles (after synchronization) produces no change.
- `step` is never high for two consecutive cycles unless two accepted transitions occur on consecutive edges. This is possible only when the phases change independently.
- No steps are generated while in INIT, which lasts `DEB_CYCLES`+3 cycles after `reset` deasserts.

## Test plan
- **Reset and CW rotation:** reset 2 cycles with inputs 00, wait 10 cycles, then drive 00→01→11→10→00, each phase held 10 cycles → 4 `step` pulses, each 1 cycle wide and 6 cycles after its input edge; `UD`=1; `LED`=4; `err`=0.
- **CCW wrap:** after reset at 00, drive 00→10 and hold → one `step`, `UD`=0, `LED`=15.
- **Glitch rejection:** at rest 00, pulse `enc_a` high for 3 cycles → no `step`, `LED` and `UD` unchanged. Then a bounce train (1,0,1,0 per cycle) followed by a steady 1 → exactly one `step`.
- **Illegal transition:** in S00, switch both inputs to 11 on the same cycle → `err`=1 and no `step`. Then a legal 11→10 gives `step` with `UD`=1, and `err` stays 1.
- **Power-up at a non-zero phase:** hold inputs at 11 through reset release → no `step`, no `err`, FSM reaches S11. A subsequent 11→01 produces `UD`=0 and `LED`=15.
- **Reset mid-operation:** assert `reset` 3 cycles after an input change, before it is accepted → all outputs return to reset values, and no `step` appears afterward for that change.

Source files
------------

// File: rtl/quad_dir_decoder.sv
// Quadrature encoder front end: synchronize, debounce, track the Gray-code
// phase and emit direction, step pulses, a 4-bit position and a sticky error.
module quad_dir_decoder #(
    parameter int DEB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enc_a,
    input  logic       enc_b,
    output logic       UD,
    output logic       step,
    output logic       err,
    output logic [3:0] LED
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam int IW = $clog2(DEB_CYCLES + 3);
    localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);
    localparam logic [IW-1:0] IMAX = IW'(DEB_CYCLES + 2);

    typedef enum logic [2:0] {
        S00  = 3'b000,
        S01  = 3'b001,
        S11  = 3'b011,
        S10  = 3'b010,
        INIT = 3'b100
    } state_t;

    logic          a_m, a_s, b_m, b_s;
    logic          a_st, b_st;
    logic [CW-1:0] a_cnt, b_cnt;
    logic [IW-1:0] init_cnt;
    logic [1:0]    ph;
    state_t        state;

    assign ph = {a_st, b_st};

    always_ff @(posedge clk) begin
        if (reset) begin
            a_m <= 1'b0;
            a_s <= 1'b0;
            b_m <= 1'b0;
            b_s <= 1'b0;
        end else begin
            a_m <= enc_a;
            a_s <= a_m;
            b_m <= enc_b;
            b_s <= b_m;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_st  <= 1'b0;
            a_cnt <= '0;
        end else if (a_s == a_st) begin
            a_cnt <= '0;
        end else if (a_cnt == CMAX) begin
            a_st  <= a_s;
            a_cnt <= '0;
        end else begin
            a_cnt <= a_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            b_st  <= 1'b0;
            b_cnt <= '0;
        end else if (b_s == b_st) begin
            b_cnt <= '0;
        end else if (b_cnt == CMAX) begin
            b_st  <= b_s;
            b_cnt <= '0;
        end else begin
            b_cnt <= b_cnt + 1'b1;
        end
    end

    // Clockwise successor of a phase: 00 -> 01 -> 11 -> 10 -> 00
    function automatic logic [1:0] cw_of(input logic [1:0] p);
        case (p)
            2'b00:   cw_of = 2'b01;
            2'b01:   cw_of = 2'b11;
            2'b11:   cw_of = 2'b10;
            default: cw_of = 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] ccw_of(input logic [1:0] p);
        case (p)
            2'b00:   ccw_of = 2'b10;
            2'b10:   ccw_of = 2'b11;
            2'b11:   ccw_of = 2'b01;
            default: ccw_of = 2'b00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= INIT;
            init_cnt <= '0;
            step     <= 1'b0;
            UD       <= 1'b1;
            err      <= 1'b0;
            LED      <= 4'd0;
        end else begin
            step <= 1'b0;
            if (state == INIT) begin
                if (init_cnt == IMAX) begin
                    state <= state_t'({1'b0, ph});
                end else begin
                    init_cnt <= init_cnt + 1'b1;
                end
            end else begin
                unique case (1'b1)
                    ph == state[1:0]: ;
                    ph == cw_of(state[1:0]): begin
                        step <= 1'b1;
                        UD   <= 1'b1;
                        LED  <= LED + 4'd1;
                    end
                    ph == ccw_of(state[1:0]): begin
                        step <= 1'b1;
                        UD   <= 1'b0;
                        LED  <= LED - 4'd1;
                    end
                    default: err <= 1'b1;
                endcase
                state <= state_t'({1'b0, ph});
            end
        end
    end

endmodule

// File: tb/tb_quad_dir_decoder.sv
// Bench for quad_dir_decoder: directed plan scenarios plus random segments,
// scored against a run-length / quarter-turn reference model.
module tb_quad_dir_decoder;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enc_a = 1'b0;
    logic       enc_b = 1'b0;
    logic       UD, step, err;
    logic [3:0] LED;

    always #5 clk = ~clk;

    quad_dir_decoder #(.DEB_CYCLES(DEB)) dut (
        .clk  (clk),
        .reset(reset),
        .enc_a(enc_a),
        .enc_b(enc_b),
        .UD   (UD),
        .step (step),
        .err  (err),
        .LED  (LED)
    );

    typedef struct {
        int       edge_n;
        bit       ud;
        bit [3:0] led;
    } exp_t;

    exp_t sbq[$];
    bit   ha[$];
    bit   hb[$];

    int       checks = 0;
    int       errors = 0;
    int       nsteps = 0;
    int       edge_n = 0;
    bit       rst_edge = 1'b0;
    bit       m_init_done = 1'b0;
    bit [1:0] m_phase = 2'b00;
    bit [1:0] acc_prev = 2'b00;
    bit [3:0] m_pos = 4'd0;
    bit       m_ud = 1'b1;
    bit       m_err = 1'b0;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)",
                     name, act, exp, edge_n, $time);
        end
    endtask

    // Raw input as sampled on post-reset edge i; before edge 1 it is 0.
    function automatic bit samp(int i, bit is_a);
        if (i < 1) return 1'b0;
        return is_a ? ha[i-1] : hb[i-1];
    endfunction

    // Accepted level = value of the latest run of DEB identical samples.
    function automatic bit settled(int upto, bit is_a);
        bit v;
        bit ok;
        for (int j = upto; j >= 1; j--) begin
            v  = samp(j, is_a);
            ok = 1'b1;
            for (int k = 1; k < DEB; k++)
                if (samp(j - k, is_a) != v) ok = 1'b0;
            if (ok) return v;
        end
        return 1'b0;
    endfunction

    // Position of a phase along the clockwise cycle 00,01,11,10.
    function automatic int gidx(bit [1:0] p);
        return 2 * p[1] + (p[1] ^ p[0]);
    endfunction

    always @(posedge clk) begin : model
        bit [1:0] acc_now;
        int       d;
        exp_t     e;
        if (reset) begin
            rst_edge    = 1'b1;
            edge_n      = 0;
            ha.delete();
            hb.delete();
            sbq.delete();
            m_pos       = 4'd0;
            m_ud        = 1'b1;
            m_err       = 1'b0;
            m_init_done = 1'b0;
            m_phase     = 2'b00;
            acc_prev    = 2'b00;
        end else begin
            rst_edge = 1'b0;
            edge_n++;
            ha.push_back(enc_a);
            hb.push_back(enc_b);
            acc_now = {settled(edge_n - 2, 1'b1), settled(edge_n - 2, 1'b0)};
            if (edge_n == DEB + 3) begin
                m_phase     = acc_prev;
                m_init_done = 1'b1;
            end else if (m_init_done) begin
                d = (gidx(acc_prev) - gidx(m_phase)) & 3;
                if (d == 1 || d == 3) begin
                    m_ud  = (d == 1);
                    m_pos = (d == 1) ? m_pos + 4'd1 : m_pos - 4'd1;
                    e.edge_n = edge_n;
                    e.ud     = m_ud;
                    e.led    = m_pos;
                    sbq.push_back(e);
                end else if (d == 2) begin
                    m_err = 1'b1;
                end
                m_phase = acc_prev;
            end
            acc_prev = acc_now;
        end
    end

    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (rst_edge) begin
            check("reset_vals", 32'({UD, step, err, LED}), 32'({1'b1, 1'b0, 1'b0, 4'd0}));
        end else begin
            if (step) begin
                nsteps++;
                if (sbq.size() == 0) begin
                    check("spurious_step", 32'(step), 0);
                end else begin
                    e = sbq.pop_front();
                    check("step_edge", edge_n, e.edge_n);
                    check("step_ud", 32'(UD), 32'(e.ud));
                    check("step_led", 32'(LED), 32'(e.led));
                end
            end else if (sbq.size() > 0 && sbq[0].edge_n <= edge_n) begin
                void'(sbq.pop_front());
                check("missed_step", 32'(step), 1);
            end
            check("state", 32'({UD, err, LED}), 32'({m_ud, m_err, m_pos}));
        end
    end

    task automatic drive(bit a, bit b, int n);
        enc_a = a;
        enc_b = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(int n);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        reset = 1'b0;
        nsteps = 0;
    endtask

    task automatic spot(string name, bit ud, bit [3:0] led, bit e, int ns);
        check({name, "_out"}, 32'({UD, err, LED}), 32'({ud, e, led}));
        check({name, "_steps"}, nsteps, ns);
    endtask

    initial begin
        @(negedge clk);

        drive(0, 0, 0);
        do_reset(2);
        drive(0, 0, 10);
        drive(0, 1, 10);
        drive(1, 1, 10);
        drive(1, 0, 10);
        drive(0, 0, 10);
        spot("cw", 1'b1, 4'd4, 1'b0, 4);

        do_reset(2);
        drive(0, 0, 10);
        drive(1, 0, 15);
        spot("ccw_wrap", 1'b0, 4'd15, 1'b0, 1);

        do_reset(2);
        drive(0, 0, 10);
        drive(1, 0, 3);
        drive(0, 0, 12);
        spot("glitch", 1'b1, 4'd0, 1'b0, 0);
        drive(1, 0, 1);
        drive(0, 0, 1);
        drive(1, 0, 1);
        drive(0, 0, 1);
        drive(1, 0, 15);
        spot("bounce", 1'b0, 4'd15, 1'b0, 1);

        do_reset(2);
        drive(0, 0, 10);
        drive(1, 1, 12);
        spot("diag", 1'b1, 4'd0, 1'b1, 0);
        drive(1, 0, 12);
        spot("after_diag", 1'b1, 4'd1, 1'b1, 1);

        enc_a = 1'b1;
        enc_b = 1'b1;
        do_reset(2);
        drive(1, 1, 20);
        spot("pwrup11", 1'b1, 4'd0, 1'b0, 0);
        drive(0, 1, 12);
        spot("pwrup_ccw", 1'b0, 4'd15, 1'b0, 1);

        do_reset(2);
        drive(0, 0, 10);
        drive(0, 1, 3);
        do_reset(3);
        spot("mid_reset", 1'b1, 4'd0, 1'b0, 0);
        drive(0, 1, 20);
        spot("mid_reset_after", 1'b1, 4'd0, 1'b0, 0);

        do_reset(2);
        for (int s = 0; s < 300; s++) begin
            if ($urandom_range(0, 39) == 0)
                do_reset(1 + $urandom_range(0, 2));
            else
                drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1 + $urandom_range(0, 11));
        end
        drive(enc_a, enc_b, 20);
        check("sb_drain", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
